conv_window_sequencer: RTL and testbench
========================================

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameters: width_b = 7 (column address bits, max 80 columns); height_b = 3 (row address bits, max 8 rows).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle job request, sampled only in IDLE.
REQ-005 SHALL have port ready, input, 1 bit: downstream accepts the current tap set; when low, the sequencer stalls.
REQ-006 SHALL have port cfg_cols_m1, input, 7 bits: fmap columns minus 1, legal range 0..79.
REQ-007 SHALL have port cfg_rows_m1, input, 3 bits: fmap rows minus 1, range 0..7.
REQ-008 SHALL have port cfg_ch_m1, input, 3 bits: input channel groups minus 1, range 0..7.
REQ-009 SHALL have port readi_wr, output, 63 bits: nine 7-bit tap column addresses; tap k at bits [62-7k -: 7].
REQ-010 SHALL have port readi_hr, output, 27 bits: nine 3-bit tap row addresses; tap k at bits [26-3k -: 3].
REQ-011 SHALL have port en_read, output, 9 bits: tap k valid at bit 8-k; 0 means zero-pad.
REQ-012 SHALL have port en_bias, output, 1 bit: add bias on this tap set.
REQ-013 SHALL have port stepr, output, 3 bits: current channel group index.
REQ-014 SHALL have outputs valid, busy, done and pix_last, 1 bit each: tap set valid; job active; one-cycle job-complete pulse; last channel of the current pixel.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after the final tap set is accepted; DONE->IDLE after exactly 1 cycle.
REQ-016 SHALL capture cfg_* into internal registers on the start cycle and ignore cfg_* changes during the job.
REQ-017 SHALL iterate, innermost first: channel group ch 0..cfg_ch_m1, then column c 0..cfg_cols_m1, then row r 0..cfg_rows_m1 (stride 1, pad 1, output size equals input size).
REQ-018 SHALL define tap k = 3*dy + dx (dy, dx in 0..2) with tap column c+dx-1 and tap row r+dy-1.
REQ-019 SHALL drive tap k as en_read bit 0 with address fields 0 when its column is <0 or >cfg_cols_m1, or its row is <0 or >cfg_rows_m1; otherwise it SHALL drive the bit 1 with the computed address.
REQ-020 SHALL assert en_bias only when ch = 0, and SHALL assert pix_last only when ch = cfg_ch_m1.
REQ-021 SHALL drive stepr = ch.
REQ-022 SHALL register all outputs.
REQ-023 SHALL assert valid in RUN starting from the cycle after start.
REQ-024 SHALL, in RUN with valid=1 and ready=1, advance to the next tap set on the next cycle.
REQ-025 SHALL, with ready=0, hold all outputs and counters unchanged.
REQ-026 SHALL wrap counters as follows: ch at cfg_ch_m1 wraps to 0 and increments c; c at cfg_cols_m1 wraps to 0 and increments r; acceptance at (r, c, ch) = all maxima ends the job.
REQ-027 SHALL hold busy high in RUN and DONE, and SHALL pulse done in DONE only.
REQ-028 SHALL ignore start while busy.
REQ-029 SHALL produce a job of exactly (cfg_rows_m1+1)*(cfg_cols_m1+1)*(cfg_ch_m1+1) accepted tap sets.
REQ-030 SHALL, for a 1x1 fmap, enable only the center tap (en_read = 9'b000010000).
REQ-031 SHALL treat cfg_cols_m1 > 79 as illegal with undefined addresses, but SHALL still complete the job without hanging.

Reset
REQ-032 SHALL, while rst_n = 0, immediately force state IDLE, all counters 0, and readi_wr, readi_hr, en_read, en_bias, stepr, valid, busy, done and pix_last to 0.
REQ-033 SHALL, when rst_n is asserted mid-job, abandon the job without a done pulse.
REQ-034 SHALL, after rst_n deasserts, require a new start.

Verification
REQ-035 SHALL cover: cols_m1=3, rows_m1=2, ch_m1=0, ready=1 -> 12 tap sets; first set en_read=9'b000011011 with center col 0, row 0; last set en_read=9'b110110000; done 1 cycle after the last acceptance.
REQ-036 SHALL cover: ch_m1=2 on a 2x2 fmap -> stepr sequence 0,1,2 per pixel; en_bias=1 only on stepr=0; pix_last=1 only on stepr=2; 12 sets total.
REQ-037 SHALL cover: ready toggled pseudo-randomly -> accepted sequence identical to the ready=1 run, and outputs stable while ready=0.
REQ-038 SHALL cover: 1x1 fmap, ch_m1=0 -> one set, en_read=9'b000010000, all addresses 0, done pulses.
REQ-039 SHALL cover: 80x8 fmap -> corner (r=7, c=79) en_read=9'b110110000 with center col 79, row 7.
REQ-040 SHALL cover: rst_n pulled low mid-job and start reasserted during busy -> outputs 0 immediately, no done pulse, and the busy-time start has no effect.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// -----------------------------------------------------------------------------
// conv_window_sequencer
//
// Walks a feature map for a 3x3, stride-1, pad-1 convolution and emits one
// registered tap set per accepted cycle. Iteration order, innermost first:
// channel group, column, row. Each tap set carries nine (column, row) read
// addresses plus a per-tap enable; taps that fall outside the map are
// reported as zero-pad (enable 0, address 0).
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : one-cycle job request, honoured only when idle
//   ready         : downstream accepts the current tap set; low stalls
//   cfg_cols_m1   : map columns minus 1 (captured on start)
//   cfg_rows_m1   : map rows minus 1    (captured on start)
//   cfg_ch_m1     : channel groups minus 1 (captured on start)
//   readi_wr      : nine tap column addresses, tap k at [(8-k)*width_b +: width_b]
//   readi_hr      : nine tap row addresses,    tap k at [(8-k)*height_b +: height_b]
//   en_read       : tap k valid at bit 8-k
//   en_bias       : first channel group of a pixel
//   stepr         : current channel group index
//   valid         : tap set valid
//   busy          : job active (RUN or DONE)
//   done          : one-cycle job-complete pulse
//   pix_last      : last channel group of the current pixel
// -----------------------------------------------------------------------------
module conv_window_sequencer #(
    parameter int width_b  = 7,
    parameter int height_b = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    ready,
    input  logic [width_b-1:0]      cfg_cols_m1,
    input  logic [height_b-1:0]     cfg_rows_m1,
    input  logic [2:0]              cfg_ch_m1,
    output logic [9*width_b-1:0]    readi_wr,
    output logic [9*height_b-1:0]   readi_hr,
    output logic [8:0]              en_read,
    output logic                    en_bias,
    output logic [2:0]              stepr,
    output logic                    valid,
    output logic                    busy,
    output logic                    done,
    output logic                    pix_last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Job configuration captured on start.
    logic [width_b-1:0]  cols_q, cols_d;
    logic [height_b-1:0] rows_q, rows_d;
    logic [2:0]          chm_q,  chm_d;

    // Position of the tap set currently presented on the outputs.
    logic [height_b-1:0] r_q, r_d;
    logic [width_b-1:0]  c_q, c_d;
    logic [2:0]          ch_q, ch_d;

    // Registered outputs.
    logic [9*width_b-1:0]  wr_q, wr_d;
    logic [9*height_b-1:0] hr_q, hr_d;
    logic [8:0]            en_q, en_d;
    logic                  bias_q, bias_d;
    logic [2:0]            stepr_q, stepr_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pix_last_q, pix_last_d;

    // Control strobes from the FSM to the output stage.
    logic load_taps;   // present the tap set at (r_d, c_d, ch_d) next cycle
    logic clear_taps;  // drive tap outputs to zero next cycle
    logic last_set;

    // Tap set for the next position, derived combinationally.
    logic [9*width_b-1:0]  tap_wr;
    logic [9*height_b-1:0] tap_hr;
    logic [8:0]            tap_en;

    // -------------------------------------------------------------------------
    // FSM and position counters
    // -------------------------------------------------------------------------
    assign last_set = (ch_q == chm_q) && (c_q == cols_q) && (r_q == rows_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        chm_d      = chm_q;
        r_d        = r_q;
        c_d        = c_q;
        ch_d       = ch_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_taps  = 1'b0;
        clear_taps = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cols_d    = cfg_cols_m1;
                    rows_d    = cfg_rows_m1;
                    chm_d     = cfg_ch_m1;
                    r_d       = '0;
                    c_d       = '0;
                    ch_d      = '0;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    load_taps = 1'b1;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                // valid is always high in RUN, so ready alone is acceptance.
                if (ready) begin
                    if (last_set) begin
                        r_d        = '0;
                        c_d        = '0;
                        ch_d       = '0;
                        valid_d    = 1'b0;
                        done_d     = 1'b1;
                        clear_taps = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        load_taps = 1'b1;
                        if (ch_q == chm_q) begin
                            ch_d = '0;
                            if (c_q == cols_q) begin
                                c_d = '0;
                                r_d = r_q + 1'b1;
                            end else begin
                                c_d = c_q + 1'b1;
                            end
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                valid_d    = 1'b0;
                busy_d     = 1'b0;
                clear_taps = 1'b1;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Tap geometry: tap k = 3*dy + dx sits at (c+dx-1, r+dy-1). Signed
    // arithmetic makes the -1 neighbour of column/row 0 fall below zero.
    // -------------------------------------------------------------------------
    always_comb begin
        tap_wr = '0;
        tap_hr = '0;
        tap_en = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                int col;
                int row;
                int k;
                col = int'(c_d) + dx - 1;
                row = int'(r_d) + dy - 1;
                k   = 3 * dy + dx;
                if (col >= 0 && col <= int'(cols_d) &&
                    row >= 0 && row <= int'(rows_d)) begin
                    tap_en[8-k] = 1'b1;
                    tap_wr[(8-k)*width_b +: width_b]   = width_b'(col);
                    tap_hr[(8-k)*height_b +: height_b] = height_b'(row);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output stage: hold by default, so a stall (ready low) freezes everything.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_d       = wr_q;
        hr_d       = hr_q;
        en_d       = en_q;
        bias_d     = bias_q;
        stepr_d    = stepr_q;
        pix_last_d = pix_last_q;
        if (clear_taps) begin
            wr_d       = '0;
            hr_d       = '0;
            en_d       = '0;
            bias_d     = 1'b0;
            stepr_d    = '0;
            pix_last_d = 1'b0;
        end else if (load_taps) begin
            wr_d       = tap_wr;
            hr_d       = tap_hr;
            en_d       = tap_en;
            bias_d     = (ch_d == 3'd0);
            stepr_d    = ch_d;
            pix_last_d = (ch_d == chm_d);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cols_q     <= '0;
            rows_q     <= '0;
            chm_q      <= '0;
            r_q        <= '0;
            c_q        <= '0;
            ch_q       <= '0;
            wr_q       <= '0;
            hr_q       <= '0;
            en_q       <= '0;
            bias_q     <= 1'b0;
            stepr_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pix_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            chm_q      <= chm_d;
            r_q        <= r_d;
            c_q        <= c_d;
            ch_q       <= ch_d;
            wr_q       <= wr_d;
            hr_q       <= hr_d;
            en_q       <= en_d;
            bias_q     <= bias_d;
            stepr_q    <= stepr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pix_last_q <= pix_last_d;
        end
    end

    assign readi_wr = wr_q;
    assign readi_hr = hr_q;
    assign en_read  = en_q;
    assign en_bias  = bias_q;
    assign stepr    = stepr_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pix_last = pix_last_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_window_sequencer
//
// Directed bench for conv_window_sequencer. A small reference walk of the
// (row, column, channel) space supplies expected tap sets; key sets are also
// checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_conv_window_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [6:0]  cfg_cols_m1 = '0;
    logic [2:0]  cfg_rows_m1 = '0;
    logic [2:0]  cfg_ch_m1 = '0;
    logic [62:0] readi_wr;
    logic [26:0] readi_hr;
    logic [8:0]  en_read;
    logic        en_bias;
    logic [2:0]  stepr;
    logic        valid;
    logic        busy;
    logic        done;
    logic        pix_last;

    int checks = 0;
    int errors = 0;

    // Values captured by do_job for later hand-computed checks.
    int          n_acc;
    logic [8:0]  first_en;
    logic [6:0]  first_ccol;
    logic [2:0]  first_crow;
    logic [8:0]  last_en;
    logic [62:0] last_wr;
    logic [26:0] last_hr;
    bit          corner_seen;
    logic [8:0]  corner_en;
    logic [6:0]  corner_col;
    logic [2:0]  corner_row;

    always #5 clk = ~clk;

    conv_window_sequencer #(.width_b(7), .height_b(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ready       (ready),
        .cfg_cols_m1 (cfg_cols_m1),
        .cfg_rows_m1 (cfg_rows_m1),
        .cfg_ch_m1   (cfg_ch_m1),
        .readi_wr    (readi_wr),
        .readi_hr    (readi_hr),
        .en_read     (en_read),
        .en_bias     (en_bias),
        .stepr       (stepr),
        .valid       (valid),
        .busy        (busy),
        .done        (done),
        .pix_last    (pix_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference tap set for position (r, c) of a (rm+1) x (cm+1) map.
    task automatic exp_taps(input int r, input int c, input int cm, input int rm,
                            output logic [8:0] en, output logic [62:0] wr,
                            output logic [26:0] hr);
        en = '0;
        wr = '0;
        hr = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                int rr;
                int cc;
                int k;
                rr = r + dy - 1;
                cc = c + dx - 1;
                k  = 3 * dy + dx;
                if (rr >= 0 && rr <= rm && cc >= 0 && cc <= cm) begin
                    en[8-k]         = 1'b1;
                    wr[62-7*k -: 7] = 7'(cc);
                    hr[26-3*k -: 3] = 3'(rr);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " readi_wr"}, 64'(readi_wr), 64'd0);
        check({tag, " readi_hr"}, 64'(readi_hr), 64'd0);
        check({tag, " en_read"},  64'(en_read),  64'd0);
        check({tag, " en_bias"},  64'(en_bias),  64'd0);
        check({tag, " stepr"},    64'(stepr),    64'd0);
        check({tag, " valid"},    64'(valid),    64'd0);
        check({tag, " busy"},     64'(busy),     64'd0);
        check({tag, " done"},     64'(done),     64'd0);
        check({tag, " pix_last"}, 64'(pix_last), 64'd0);
    endtask

    // Runs one complete job; entered and left at 1 time unit after a rising edge.
    task automatic do_job(input int cm, input int rm, input int hm,
                          input bit rnd, input bit chk_addr, input string tag);
        int          er;
        int          ec;
        int          ech;
        int          budget;
        bit          fin;
        bit          prev_ready;
        logic [8:0]  en_e;
        logic [62:0] wr_e;
        logic [26:0] hr_e;
        logic [8:0]  hold_en;
        logic [62:0] hold_wr;
        logic [2:0]  hold_step;
        er = 0; ec = 0; ech = 0; budget = 0; fin = 1'b0; prev_ready = 1'b1;
        hold_en = '0; hold_wr = '0; hold_step = '0;
        n_acc = 0;
        corner_seen = 1'b0;

        cfg_cols_m1 = 7'(cm);
        cfg_rows_m1 = 3'(rm);
        cfg_ch_m1   = 3'(hm);
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the configuration: the job must use the captured copy.
        cfg_cols_m1 = ~cfg_cols_m1;
        cfg_rows_m1 = ~cfg_rows_m1;
        cfg_ch_m1   = ~cfg_ch_m1;

        while (!fin && budget < 5000) begin
            budget++;
            check({tag, " valid"}, 64'(valid), 64'd1);
            check({tag, " busy"},  64'(busy),  64'd1);
            check({tag, " done"},  64'(done),  64'd0);
            if (chk_addr) begin
                exp_taps(er, ec, cm, rm, en_e, wr_e, hr_e);
                check({tag, " en_read"},  64'(en_read),  64'(en_e));
                check({tag, " readi_wr"}, 64'(readi_wr), 64'(wr_e));
                check({tag, " readi_hr"}, 64'(readi_hr), 64'(hr_e));
            end
            check({tag, " stepr"},    64'(stepr),    64'(ech));
            check({tag, " en_bias"},  64'(en_bias),  64'(ech == 0));
            check({tag, " pix_last"}, 64'(pix_last), 64'(ech == hm));
            if (!prev_ready) begin
                check({tag, " hold en_read"},  64'(en_read),  64'(hold_en));
                check({tag, " hold readi_wr"}, 64'(readi_wr), 64'(hold_wr));
                check({tag, " hold stepr"},    64'(stepr),    64'(hold_step));
            end
            if (budget == 1) begin
                first_en   = en_read;
                first_ccol = readi_wr[34:28];
                first_crow = readi_hr[14:12];
            end
            if (er == 7 && ec == 79 && !corner_seen) begin
                corner_seen = 1'b1;
                corner_en   = en_read;
                corner_col  = readi_wr[34:28];
                corner_row  = readi_hr[14:12];
            end
            hold_en   = en_read;
            hold_wr   = readi_wr;
            hold_step = stepr;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_ready = ready;
            if (ready) begin
                n_acc++;
                last_en = en_read;
                last_wr = readi_wr;
                last_hr = readi_hr;
                if (ech == hm) begin
                    ech = 0;
                    if (ec == cm) begin
                        ec = 0;
                        if (er == rm) fin = 1'b1;
                        else er++;
                    end else begin
                        ec++;
                    end
                end else begin
                    ech++;
                end
            end
            @(posedge clk); #1;
        end
        check({tag, " finished in budget"}, 64'(fin), 64'd1);
        ready = 1'b1;
        // One cycle after the final acceptance: DONE with the done pulse.
        check({tag, " done pulse"},    64'(done),    64'd1);
        check({tag, " done busy"},     64'(busy),    64'd1);
        check({tag, " done valid"},    64'(valid),   64'd0);
        check({tag, " done en_read"},  64'(en_read), 64'd0);
        @(posedge clk); #1;
        check({tag, " idle done"},     64'(done),    64'd0);
        check({tag, " idle busy"},     64'(busy),    64'd0);
        check({tag, " set count"},     64'(n_acc),   64'((cm + 1) * (rm + 1) * (hm + 1)));
    endtask

    initial begin
        // Reset: outputs zero while rst_n is low.
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle after reset");

        // 4x3 map, single channel group, ready always high.
        do_job(3, 2, 0, 1'b0, 1'b1, "A");
        check("A first en_read",    64'(first_en),   64'b000011011);
        check("A first center col", 64'(first_ccol), 64'd0);
        check("A first center row", 64'(first_crow), 64'd0);
        check("A last en_read",     64'(last_en),    64'b110110000);

        // 2x2 map, three channel groups.
        do_job(1, 1, 2, 1'b0, 1'b1, "B");

        // Random stalls on a multi-channel map.
        do_job(3, 2, 1, 1'b1, 1'b1, "C");

        // 1x1 map: only the center tap, all addresses zero.
        do_job(0, 0, 0, 1'b0, 1'b1, "D");
        check("D en_read",  64'(last_en), 64'b000010000);
        check("D readi_wr", 64'(last_wr), 64'd0);
        check("D readi_hr", 64'(last_hr), 64'd0);

        // 80x8 map: far corner.
        do_job(79, 7, 0, 1'b0, 1'b1, "E");
        check("E corner seen",       64'(corner_seen), 64'd1);
        check("E corner en_read",    64'(corner_en),   64'b110110000);
        check("E corner center col", 64'(corner_col),  64'd79);
        check("E corner center row", 64'(corner_row),  64'd7);

        // Illegal column count: addresses undefined, job must still end.
        do_job(100, 0, 0, 1'b0, 1'b0, "illegal");

        // Mid-job start is ignored; mid-job reset abandons the job.
        cfg_cols_m1 = 7'd3;
        cfg_rows_m1 = 3'd2;
        cfg_ch_m1   = 3'd0;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Three sets accepted; this edge accepts (0,3) while start is high.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("F busy start en_read", 64'(en_read),         64'b011011011);
        check("F busy start row",     64'(readi_hr[14:12]), 64'd1);
        check("F busy start valid",   64'(valid),           64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("F async reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("F no done after reset", 64'(done),  64'd0);
            check("F idle valid",          64'(valid), 64'd0);
            check("F idle busy",           64'(busy),  64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
